// File: rtl/sfp2fix_arb.sv
// Purpose: round-robin packet arbiter sharing one sfp-to-fixed converter between NREQ requesters.
// Latency: 1 cycle from beat accept to out_valid; 1 idle arbitration cycle between packets.
// Backpressure: the owner's req_ready follows ~out_valid | out_ready; all other requesters are held off.
// Build option: define SFP2FIX_ARB_FIXPRIO_EN for fixed priority (requester 0 highest).
module sfp2fix_arb #(
    parameter int NREQ        = 4,
    parameter int expWidth    = 4,
    parameter int sigWidth    = 4,
    parameter int formatWidth = 9,
    parameter int fixWidth    = 21,
    parameter int TAGW        = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0]               req_last,
    input  logic [NREQ*formatWidth-1:0]   req_sfp,
    output logic [NREQ-1:0]               req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [fixWidth-1:0]           out_fix,
    output logic [TAGW-1:0]               out_tag,
    output logic                          out_last
);

    // Width of the unshifted magnitude {hidden bit, mantissa, 7 guard zeros}.
    localparam int TW = 1 + sigWidth + 7;
    // Exponent value that means "no shift".
    localparam logic [expWidth-1:0] BIAS = expWidth'(2 ** (expWidth - 1));

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [TAGW-1:0]       owner_q, owner_d;
    logic [TAGW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [fixWidth-1:0]   out_fix_q, out_fix_d;
    logic [TAGW-1:0]       out_tag_q, out_tag_d;
    logic                  out_last_q, out_last_d;

    logic                  sel_valid;
    logic                  sel_last;
    logic [formatWidth-1:0] sel_sfp;
    logic                  pick_found;
    logic [TAGW-1:0]       pick_idx;
    logic                  accept;
    logic [TAGW-1:0]       owner_next;

    logic                  cv_s;
    logic                  cv_z;
    logic [expWidth-1:0]   cv_e;
    logic [sigWidth-1:0]   cv_m;
    logic [fixWidth-2:0]   cv_t;
    logic [fixWidth-2:0]   cv_mag;
    logic [fixWidth-1:0]   cv_fix;

    // Route the current owner's valid/last/sample to the shared converter.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_sfp   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == TAGW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_sfp   = req_sfp[i*formatWidth +: formatWidth];
            end
        end
    end

    // First valid requester at or after the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = TAGW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    // Only the locked owner may be ready, and only when the output stage can take a beat.
    always_comb begin
        req_ready = '0;
        if (state_q == LOCK) begin
            for (int i = 0; i < NREQ; i++) begin
                if (owner_q == TAGW'(i)) begin
                    req_ready[i] = ~out_valid_q | out_ready;
                end
            end
        end
    end

    assign accept     = (state_q == LOCK) && sel_valid && (~out_valid_q | out_ready);
    assign owner_next = (owner_q == TAGW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    // Shared sfp-to-fixed converter: hidden bit plus mantissa, shifted by the unbiased exponent.
    always_comb begin
        cv_s   = sel_sfp[formatWidth-1];
        cv_e   = sel_sfp[sigWidth +: expWidth];
        cv_m   = sel_sfp[sigWidth-1:0];
        cv_z   = (cv_e != '0);
        cv_t   = '0;
        cv_t[TW-1:0] = {cv_z, cv_m, 7'b0};
        if (cv_e > BIAS) begin
            cv_mag = cv_t << (cv_e - BIAS);
        end else begin
            cv_mag = cv_t >> (BIAS - cv_e);
        end
        cv_fix = {(cv_z ? cv_s : 1'b0), ((cv_s & cv_z) ? ~cv_mag : cv_mag)};
    end

    // Arbitration FSM: pick an owner in IDLE, release the lock on the owner's last accepted beat.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
`ifdef SFP2FIX_ARB_FIXPRIO_EN
                    rr_ptr_d = '0;
`else
                    rr_ptr_d = owner_next;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage: load on accept, drain on out_ready, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_fix_d   = out_fix_q;
        out_tag_d   = out_tag_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_fix_d   = cv_fix;
            out_tag_d   = owner_q;
            out_last_d  = sel_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset drops any lock and any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_fix_q   <= '0;
            out_tag_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_fix_q   <= out_fix_d;
            out_tag_q   <= out_tag_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_fix   = out_fix_q;
    assign out_tag   = out_tag_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_sfp2fix_arb.sv
module tb_sfp2fix_arb;

    localparam int NREQ = 4;
    localparam int FW   = 9;
    localparam int XW   = 21;
    localparam int TW   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_last;
    logic [NREQ*FW-1:0]   req_sfp;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [XW-1:0]        out_fix;
    logic [TW-1:0]        out_tag;
    logic                 out_last;

    sfp2fix_arb #(
        .NREQ(NREQ), .expWidth(4), .sigWidth(4), .formatWidth(FW), .fixWidth(XW), .TAGW(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_last(req_last), .req_sfp(req_sfp), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fix(out_fix), .out_tag(out_tag), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XW-1:0] fix;
        logic [TW-1:0] tag;
        logic          last;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   gap_chk = 0;
    int   last_pop = -1;
    bit   prev_last = 0;
    int   stalls = 0;
    bit   r3_watch = 0;
    bit   r0_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every output handshake pops one expected beat.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got tag %0d fix %0h, expected no beat", out_tag, out_fix);
                end else begin
                    e = q.pop_front();
                    chk("out_fix", 32'(out_fix), 32'(e.fix));
                    chk("out_tag", 32'(out_tag), 32'(e.tag));
                    chk("out_last", 32'(out_last), 32'(e.last));
                    if (gap_chk && last_pop >= 0)
                        chk("beat_gap", 32'(cyc - last_pop), 32'((prev_last ? 2 : 1) + stalls));
                    last_pop  = cyc;
                    prev_last = e.last;
                    stalls    = 0;
                end
            end else begin
                stalls++;
            end
        end
    end

    // While the owner holds the lock, a waiting requester 3 must never be granted.
    always @(negedge clk) begin
        if (r3_watch && !r0_done && req_valid[3])
            chk("r3_blocked", 32'(req_ready[3]), 32'd0);
    end

    task automatic push_pkt(input int tag, input int n, input int f0, input int step);
        exp_t x;
        for (int b = 0; b < n; b++) begin
            x.fix  = XW'(f0 + b * step);
            x.tag  = TW'(tag);
            x.last = (b == n - 1);
            q.push_back(x);
        end
    endtask

    task automatic wait_accept(input int r);
        int t = 0;
        forever begin
            @(negedge clk);
            if (req_ready[r]) begin
                @(posedge clk);
                #1;
                break;
            end
            t++;
            if (t > 300) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: requester %0d never accepted, required accept within 300 cycles", r);
                break;
            end
        end
    endtask

    // Send an n-beat packet; sample b = base + b. Optionally drop valid for gap_len cycles after beat gap_after.
    task automatic send(input int r, input int n, input logic [FW-1:0] base, input int gap_after, input int gap_len);
        for (int b = 0; b < n; b++) begin
            req_sfp[r*FW +: FW] = base + FW'(b);
            req_last[r]  = (b == n - 1);
            req_valid[r] = 1'b1;
            wait_accept(r);
            req_valid[r] = 1'b0;
            req_last[r]  = 1'b0;
            if (b == gap_after) begin
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !out_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d beats still expected, required 0", q.size());
    endtask

    task automatic wait_out_valid();
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #1;
            if (out_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL out_valid_timeout: out_valid stayed 0, required 1");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [FW-1:0]  vec_in  [5] = '{9'b0_1000_0000, 9'b1_1000_0000, 9'b1_0000_0000, 9'b0_1001_1000, 9'b0_0111_0000};
    logic [XW-1:0]  vec_out [5] = '{21'h000800, 21'h1FF7FF, 21'h000000, 21'h001800, 21'h000400};
    logic [XW-1:0]  held_fix;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_last  = '0;
        req_sfp   = '0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_out_fix",   32'(out_fix),   32'd0);
        chk("rst_out_tag",   32'(out_tag),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-beat conversions from requester 0.
        for (int i = 0; i < 5; i++) begin
            push_pkt(0, 1, int'(vec_out[i]), 0);
            send(0, 1, vec_in[i], -1, 0);
        end
        wait_drain();

        // Two requesters, two 4-beat packets each, from a fresh reset.
        do_reset();
        gap_chk  = 1;
        last_pop = -1;
        stalls   = 0;
`ifdef SFP2FIX_ARB_FIXPRIO_EN
        push_pkt(0, 4, 'h800, 'h80);
        push_pkt(0, 4, 'h800, 'h80);
        push_pkt(1, 4, 'h1000, 'h100);
        push_pkt(1, 4, 'h1000, 'h100);
`else
        push_pkt(0, 4, 'h800, 'h80);
        push_pkt(1, 4, 'h1000, 'h100);
        push_pkt(0, 4, 'h800, 'h80);
        push_pkt(1, 4, 'h1000, 'h100);
`endif
        fork
            begin send(0, 4, 9'h080, -1, 0); send(0, 4, 9'h080, -1, 0); end
            begin send(1, 4, 9'h090, -1, 0); send(1, 4, 9'h090, -1, 0); end
        join
        wait_drain();

        // Backpressure mid-packet for 5 cycles.
        last_pop = -1;
        stalls   = 0;
        push_pkt(1, 6, 'h1000, 'h100);
        fork
            send(1, 6, 9'h090, -1, 0);
            begin
                wait_out_valid();
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_req_ready", 32'(req_ready), 32'd0);
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                    if (i == 0) held_fix = out_fix;
                    else begin
                        chk("bp_fix_stable", 32'(out_fix), 32'(held_fix));
                        chk("bp_tag_stable", 32'(out_tag), 32'd1);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        gap_chk = 0;

        // Owner drops valid for 3 cycles mid-packet while requester 3 waits.
        push_pkt(0, 4, 'h800, 'h80);
        push_pkt(3, 1, 'h1FF7FF, 0);
        r0_done = 0;
        fork
            begin send(0, 4, 9'h080, 1, 3); r0_done = 1; end
            begin
                repeat (2) @(posedge clk);
                #1;
                r3_watch = 1;
                send(3, 1, 9'h180, -1, 0);
            end
        join
        wait_drain();
        r3_watch = 0;

        // Reset in the middle of a packet from requester 2.
        push_pkt(0, 1, 'h800, 0);
        send(0, 1, 9'h080, -1, 0);
        wait_drain();
        out_ready = 1'b0;
        req_sfp[2*FW +: FW] = 9'h070;
        req_last[2]  = 1'b0;
        req_valid[2] = 1'b1;
        wait_out_valid();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_out_tag",   32'(out_tag),   32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk("postrst_req_ready", 32'(req_ready), 32'd0);
        push_pkt(0, 1, 'h800, 0);
        push_pkt(2, 1, 'h400, 0);
        fork
            send(0, 1, 9'h080, -1, 0);
            send(2, 1, 9'h070, -1, 0);
        join
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
